// File: rtl/fp16_pkg.sv
// Shared binary16 constants and the divider FSM state type.
package fp16_pkg;

   localparam int unsigned EXP_W  = 5;
   localparam int unsigned MANT_W = 10;
   localparam int unsigned BIAS   = 15;
   localparam logic [15:0] QNAN   = 16'h7E00;
   localparam logic [15:0] PINF   = 16'h7C00;

   // Significand with hidden bit, and quotient width: 11 result bits + guard + round + norm bit.
   localparam int unsigned SIG_W     = MANT_W + 1;
   localparam int unsigned QUO_W     = SIG_W + 3;
   localparam int unsigned LAST_ITER = QUO_W - 1;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StRound,
      StDone
   } div_state_e;

endpackage

// File: rtl/fp16_unpack.sv
// Combinational binary16 field split and classification; exponent 0 is flushed to zero.
module fp16_unpack
   import fp16_pkg::*;
(
   input  logic [15:0]      op,
   output logic             sign,
   output logic [EXP_W-1:0] exp,
   output logic [SIG_W-1:0] sig,
   output logic             is_zero,
   output logic             is_inf,
   output logic             is_nan
);

   logic [MANT_W-1:0] mant;
   logic              exp_max;

   always_comb begin
      sign    = op[15];
      exp     = op[14:10];
      mant    = op[MANT_W-1:0];
      exp_max = &exp;
      sig     = {|exp, mant};
      is_zero = (exp == '0);
      is_inf  = exp_max && (mant == '0);
      is_nan  = exp_max && (mant != '0);
   end

endmodule

// File: rtl/fp16_div_seq.sv
// Sequential binary16 divider: restoring division one quotient bit per cycle, then one
// round/normalise cycle; fixed latency for every operand class.
module fp16_div_seq
   import fp16_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [15:0] o_res
);

   localparam logic signed [7:0] BiasS = 8'(BIAS);

   div_state_e       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [15:0]      a_q, a_d, b_q, b_d;
   logic [SIG_W:0]   rem_q, rem_d;
   logic [QUO_W-1:0] quo_q, quo_d;
   logic [15:0]      res_q, res_d;

   logic             sa, sb, za, zb, ia, ib, na, nb;
   logic [EXP_W-1:0] ea, eb;
   logic [SIG_W-1:0] ma, mb;

   fp16_unpack u_unpack_a (
      .op      (a_q),
      .sign    (sa),
      .exp     (ea),
      .sig     (ma),
      .is_zero (za),
      .is_inf  (ia),
      .is_nan  (na)
   );

   fp16_unpack u_unpack_b (
      .op      (b_q),
      .sign    (sb),
      .exp     (eb),
      .sig     (mb),
      .is_zero (zb),
      .is_inf  (ib),
      .is_nan  (nb)
   );

   // Restoring step: the first iteration seeds the partial remainder with the dividend.
   logic [SIG_W:0] rem_cur, rem_sub;
   logic           rem_ge;

   always_comb begin
      rem_cur = (cnt_q == 4'd0) ? {1'b0, ma} : rem_q;
      rem_ge  = (rem_cur >= {1'b0, mb});
      rem_sub = rem_ge ? (rem_cur - {1'b0, mb}) : rem_cur;
   end

   // Normalise, round-to-nearest-even, exponent adjust and special-case select.
   logic                q_norm, guard_b, round_b, sticky_b, rnd_up, sign_r;
   logic [SIG_W-1:0]    mant11;
   logic [SIG_W:0]      mant_r;
   logic [MANT_W-1:0]   mant_fin;
   logic signed [7:0]   exp_pre, exp_rnd;
   logic [15:0]         round_res;

   always_comb begin
      q_norm   = quo_q[QUO_W-1];
      mant11   = q_norm ? quo_q[QUO_W-1:3] : quo_q[QUO_W-2:2];
      guard_b  = q_norm ? quo_q[2] : quo_q[1];
      round_b  = q_norm ? quo_q[1] : quo_q[0];
      sticky_b = (q_norm & quo_q[0]) | (rem_q != '0);
      rnd_up   = guard_b & (round_b | sticky_b | mant11[0]);
      mant_r   = {1'b0, mant11} + {{SIG_W{1'b0}}, rnd_up};
      // A rounding carry leaves 1000_0000_0000b; shifting keeps the stored fraction zero.
      mant_fin = mant_r[SIG_W] ? mant_r[SIG_W-1:1] : mant_r[MANT_W-1:0];
      exp_pre  = $signed({3'b000, ea}) - $signed({3'b000, eb}) + BiasS
                 - (q_norm ? 8'sd0 : 8'sd1);
      exp_rnd  = exp_pre + (mant_r[SIG_W] ? 8'sd1 : 8'sd0);
      sign_r   = sa ^ sb;

      if (na || nb || (za && zb) || (ia && ib)) begin
         round_res = QNAN | {sign_r, 15'h0000};
      end else if (ia || zb) begin
         round_res = PINF | {sign_r, 15'h0000};
      end else if (za || ib) begin
         round_res = {sign_r, 15'h0000};
      end else if (exp_rnd > 8'sd30) begin
         round_res = PINF | {sign_r, 15'h0000};
      end else if (exp_rnd < 8'sd1) begin
         round_res = {sign_r, 15'h0000};
      end else begin
         round_res = {sign_r, exp_rnd[EXP_W-1:0], mant_fin};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      res_d   = res_q;
      unique case (state_q)
         StIdle: begin
            if (i_valid) begin
               a_d     = i_a;
               b_d     = i_b;
               cnt_d   = 4'd0;
               state_d = StCalc;
            end
         end
         StCalc: begin
            rem_d = rem_sub << 1;
            quo_d = {quo_q[QUO_W-2:0], rem_ge};
            if (cnt_q == 4'(LAST_ITER)) begin
               cnt_d   = 4'd0;
               state_d = StRound;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StRound: begin
            res_d   = round_res;
            state_d = StDone;
         end
         StDone: begin
            if (i_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         a_q     <= 16'h0000;
         b_q     <= 16'h0000;
         rem_q   <= '0;
         quo_q   <= '0;
         res_q   <= 16'h0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         res_q   <= res_d;
      end
   end

   assign o_ready = (state_q == StIdle);
   assign o_valid = (state_q == StDone);
   assign o_res   = res_q;

endmodule

// File: tb/tb_fp16_div_seq.sv
// Self-checking bench for fp16_div_seq: directed vectors, random operands against a
// rational-arithmetic RNE model, backpressure, back-to-back and mid-operation reset.
module tb_fp16_div_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [15:0] i_a;
   logic [15:0] i_b;
   logic        o_valid;
   logic        i_ready;
   logic [15:0] o_res;

   int errors = 0;
   int checks = 0;

   fp16_div_seq dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_a     (i_a),
      .i_b     (i_b),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_res   (o_res)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got time %0t required < 1000000", $time);
      $fatal(1, "watchdog");
   end

   // Exact quotient ma/mb * 2^(ea-eb), rounded to nearest-even on 11 significant bits.
   function automatic logic [15:0] ref_div(input logic [15:0] a, input logic [15:0] b);
      logic   s;
      int     ea, eb, fa, fb, p, be;
      longint num, q, r, keep, rest, half, ma, mb;
      logic [4:0] e5;
      logic [9:0] m10;
      s  = a[15] ^ b[15];
      ea = int'(a[14:10]);
      eb = int'(b[14:10]);
      fa = int'(a[9:0]);
      fb = int'(b[9:0]);
      if ((ea == 31 && fa != 0) || (eb == 31 && fb != 0) || (ea == 0 && eb == 0) ||
          (ea == 31 && eb == 31))
         return {s, 15'h7E00};
      if (ea == 31 || eb == 0) return {s, 15'h7C00};
      if (ea == 0 || eb == 31) return {s, 15'h0000};
      ma   = 1024 + fa;
      mb   = 1024 + fb;
      num  = ma << 24;
      q    = num / mb;
      r    = num % mb;
      p    = (q >= (longint'(1) << 24)) ? 24 : 23;
      keep = q >> (p - 10);
      rest = q & ((longint'(1) << (p - 10)) - 1);
      half = longint'(1) << (p - 11);
      if (rest > half || (rest == half && (r != 0 || keep % 2 == 1))) keep = keep + 1;
      if (keep == 2048) begin
         keep = 1024;
         p    = p + 1;
      end
      be = p - 24 + ea - eb + 15;
      if (be > 30) return {s, 15'h7C00};
      if (be < 1) return {s, 15'h0000};
      e5  = be[4:0];
      m10 = keep[9:0];
      return {s, e5, m10};
   endfunction

   task automatic do_reset();
      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_a     = 16'h0000;
      i_b     = 16'h0000;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Present an operand pair from a negedge; returns after the accept edge.
   task automatic start_op(input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      i_a     = a;
      i_b     = b;
      i_valid = 1'b1;
      @(posedge clk);
      #1 i_valid = 1'b0;
   endtask

   // Cycle index (1 = first cycle after the accept edge) at which o_valid is seen; -1 on timeout.
   task automatic wait_valid(output int lat);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (o_valid === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic consume();
      i_ready = 1'b1;
      @(posedge clk);
      #1 i_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++;
      if (o_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b required 1", o_ready);
      end
      checks++;
      if (o_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b required 0", o_valid);
      end
      checks++;
      if (o_res !== 16'h0000) begin
         errors++;
         $display("FAIL reset_res: got %h required 0000", o_res);
      end
      do_reset();
   endtask

   task automatic test_directed();
      logic [15:0] va [12] = '{16'h3C00, 16'h4200, 16'h3C00, 16'h3C00, 16'h7C00, 16'h0000,
                               16'h3C00, 16'hBC00, 16'h3C00, 16'h7BFF, 16'h0400, 16'h0001};
      logic [15:0] vb [12] = '{16'h4000, 16'h4000, 16'h4200, 16'h3C00, 16'h7C00, 16'h0000,
                               16'h0000, 16'h0000, 16'h7C00, 16'h0400, 16'h7BFF, 16'h3C00};
      logic [15:0] vq [12] = '{16'h3800, 16'h3E00, 16'h3555, 16'h3C00, 16'h7E00, 16'h7E00,
                               16'h7C00, 16'hFC00, 16'h0000, 16'h7C00, 16'h0000, 16'h0000};
      int lat;
      for (int i = 0; i < 12; i++) begin
         start_op(va[i], vb[i]);
         wait_valid(lat);
         checks++;
         if (lat !== 16) begin
            errors++;
            $display("FAIL directed_latency %h/%h: got cycle %0d required 16", va[i], vb[i], lat);
         end
         checks++;
         if (o_res !== vq[i]) begin
            errors++;
            $display("FAIL directed_result %h/%h: got %h required %h", va[i], vb[i], o_res, vq[i]);
         end
         consume();
      end
   endtask

   task automatic test_random();
      logic [15:0] a, b, exp_q;
      logic [31:0] rnd;
      int          lat;
      for (int i = 0; i < 60; i++) begin
         rnd = $urandom;
         if ($urandom_range(0, 3) == 0) begin
            a = rnd[15:0];
            b = rnd[31:16];
         end else begin
            a = {rnd[0], 5'($urandom_range(3, 28)), rnd[10:1]};
            b = {rnd[11], 5'($urandom_range(3, 28)), rnd[21:12]};
         end
         exp_q = ref_div(a, b);
         start_op(a, b);
         wait_valid(lat);
         checks++;
         if (lat !== 16 || o_res !== exp_q) begin
            errors++;
            $display("FAIL random %h/%h: got %h at cycle %0d required %h at cycle 16",
                     a, b, o_res, lat, exp_q);
         end
         consume();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      start_op(16'h4200, 16'h4000);
      wait_valid(lat);
      for (int k = 0; k < 5; k++) begin
         i_valid = k[0];
         i_a     = 16'h3C00;
         i_b     = 16'h3C00;
         @(negedge clk);
         checks++;
         if (o_valid !== 1'b1 || o_res !== 16'h3E00 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_cycle%0d: got valid=%b res=%h ready=%b required valid=1 res=3e00 ready=0",
                     k, o_valid, o_res, o_ready);
         end
      end
      i_valid = 1'b0;
      consume();
      @(negedge clk);
      checks++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_release: got ready=%b valid=%b required ready=1 valid=0",
                  o_ready, o_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] a, b;
      int          lat;
      i_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = {1'b0, 5'($urandom_range(10, 20)), 10'($urandom)};
         b = {1'b1, 5'($urandom_range(10, 20)), 10'($urandom)};
         start_op(a, b);
         i_ready = 1'b1;
         wait_valid(lat);
         checks++;
         if (lat !== 16 || o_res !== ref_div(a, b)) begin
            errors++;
            $display("FAIL b2b_result %h/%h: got %h at cycle %0d required %h at cycle 16",
                     a, b, o_res, lat, ref_div(a, b));
         end
         @(negedge clk);
         checks++;
         if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_oneshot: got valid=%b ready=%b required valid=0 ready=1",
                     o_valid, o_ready);
         end
      end
      i_ready = 1'b0;
   endtask

   task automatic test_reset_abort();
      int lat;
      start_op(16'h3C00, 16'h4200);
      repeat (7) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_res !== 16'h0000) begin
         errors++;
         $display("FAIL abort_reset: got ready=%b valid=%b res=%h required ready=1 valid=0 res=0000",
                  o_ready, o_valid, o_res);
      end
      @(negedge clk);
      rst_n = 1'b1;
      start_op(16'h4200, 16'h4000);
      wait_valid(lat);
      checks++;
      if (lat !== 16 || o_res !== 16'h3E00) begin
         errors++;
         $display("FAIL abort_next: got %h at cycle %0d required 3e00 at cycle 16", o_res, lat);
      end
      consume();
   endtask

   initial begin
      do_reset();
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
